semaforo_monitor: RTL
=====================

Name: semaforo_monitor

Overview:
- Passive checker/decoder on the observer side of the traffic-light interface.
- Samples the three lamp lines (rojo, amarillo, verde) on each 1 s tick and decodes them into a phase code.
- Locks onto the light cycle and checks three things: one-hot lamp pattern, phase order rojo→verde→amarillo→rojo, and phase durations in ticks.
- Counts completed cycles. Flags the first violation sticky until reset.

Parameters:
- T_ROJO, 2, required rojo duration in ticks (1..15).
- T_VERDE, 5, required verde duration in ticks (1..15).
- T_AMARILLO, 2, required amarillo duration in ticks (1..15).
- CW, 8, width of completed-cycle counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  sample enable, 1-cycle pulse every second.
- rojo  in  1  red lamp line.
- amarillo  in  1  amber lamp line.
- verde  in  1  green lamp line.
- fase  out  2  decoded phase: 0 rojo, 1 verde, 2 amarillo, 3 unsynced/error.
- sync  out  1  monitor locked and no error.
- err  out  1  sticky violation flag.
- err_code  out  3  first violation: 0 none, 1 illegal pattern, 2 phase too long, 3 phase too short, 4 illegal transition.
- ciclos  out  CW  completed amarillo→rojo transitions, saturating.

Behaviour:
- All outputs are registered. Reset values: fase=3, sync=0, err=0, err_code=0, ciclos=0. Internal state is S_INIT and duration count is 0.
- rst is synchronous and has priority over everything, tick included. Asserting it mid-operation returns the block to reset values on that edge.
- tick=0: state, count and all outputs hold.
- Lamp samples are evaluated only on edges with tick=1. Results are visible the cycle after that edge.
- Pattern decode: exactly one lamp lit gives that colour. Zero lamps or more than one lamp lit is an illegal pattern.
- States: S_INIT, S_ROJO, S_VERDE, S_AMARILLO, S_ERR. Duration counter dur is 4 bits.
- S_INIT:
  - Any sample other than lone rojo is ignored; no error is raised.
  - A lone rojo sample moves to S_ROJO with dur=1, sets first-phase flag primera=1, fase=0, sync=1.
- Locked states (S_ROJO, S_VERDE, S_AMARILLO), on a tick. Checks are evaluated in this priority order:
  1. Illegal pattern → err_code=1.
  2. Same colour as current phase:
     - dur==T_phase → err_code=2.
     - Otherwise dur=dur+1.
  3. Legal successor colour (rojo→verde, verde→amarillo, amarillo→rojo):
     - dur!=T_phase → err_code=3. Exception: leaving the first rojo phase with primera=1 skips the short check.
     - Otherwise enter the next state, dur=1, primera=0, fase updated.
     - Amarillo→rojo also increments ciclos, saturating at all-ones.
  4. Any other colour change (rojo→amarillo, verde→rojo, amarillo→verde) → err_code=4.
- On any violation:
  - Next state is S_ERR; err=1, sync=0, fase=3.
  - err_code latches the code of that violation.
  - ciclos freezes.
- S_ERR: holds until rst. Subsequent ticks change nothing, and err_code never updates after the first error.
- Boundary cases:
  - Bound checks are exact equality against T_*, so T_*=1 means a single-tick phase.
  - ciclos at max stays at max.
  - Simultaneous rst and tick: the reset wins.

Test Plan:
1. Reset, then golden sequence (R×2, G×5, Y×2) ×3 with tick every cycle, then one more R.
   → sync=1 from the tick after the first R; fase tracks 0/1/2; ciclos=3; err=0.
2. Golden start, but verde held 6 ticks.
   → on the 6th verde tick: err=1, err_code=2, sync=0, fase=3.
3. Golden start, verde for 4 ticks then amarillo.
   → at the amarillo tick: err_code=3; ciclos stays 0.
4. R×2 then amarillo.
   → err_code=4.
5. Next ticks:
   - Lock, then rojo+verde both lit → err_code=1.
   - Then 5 more ticks of golden input → outputs unchanged.
   - Then rst for one cycle → all reset values.
6. Next ticks:
   - Begin stimulus mid-verde (G×3, Y×2) → INIT ignores it, sync=0.
   - Then R×1, G×5, Y×2, R with tick every 3rd cycle → short first rojo is accepted, ciclos=1, err=0, outputs hold between ticks.
   - CW=2 variant with 5 golden cycles → ciclos saturates at 3.

Source files
------------

// File: rtl/semaforo_monitor.sv
// Passive traffic-light observer: decodes lamp samples on each tick, locks onto the
// rojo->verde->amarillo cycle, checks pattern/order/duration and counts full cycles.
module semaforo_monitor #(
  parameter int T_ROJO     = 2,
  parameter int T_VERDE    = 5,
  parameter int T_AMARILLO = 2,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          rojo,
  input  logic          amarillo,
  input  logic          verde,
  output logic [1:0]    fase,
  output logic          sync,
  output logic          err,
  output logic [2:0]    err_code,
  output logic [CW-1:0] ciclos
);

  typedef enum logic [2:0] {S_INIT, S_ROJO, S_VERDE, S_AMARILLO, S_ERR} state_t;

  localparam logic [3:0] L_ROJO     = 4'(T_ROJO);
  localparam logic [3:0] L_VERDE    = 4'(T_VERDE);
  localparam logic [3:0] L_AMARILLO = 4'(T_AMARILLO);

  state_t          r_state, w_state_nx;
  logic [3:0]      r_dur, w_dur_nx;
  logic            r_primera, w_primera_nx;
  logic [1:0]      w_fase_nx;
  logic            w_sync_nx, w_err_nx;
  logic [2:0]      w_code_nx;
  logic [CW-1:0]   w_ciclos_nx;

  logic            w_one_hot;
  logic [1:0]      w_col, w_cur_col, w_succ_col;
  logic [3:0]      w_limit;
  logic            w_viol;
  logic [2:0]      w_vcode;

  function automatic state_t col2state(input logic [1:0] col);
    case (col)
      2'd0:    return S_ROJO;
      2'd1:    return S_VERDE;
      default: return S_AMARILLO;
    endcase
  endfunction

  assign w_one_hot = ({rojo, verde, amarillo} == 3'b100) ||
                     ({rojo, verde, amarillo} == 3'b010) ||
                     ({rojo, verde, amarillo} == 3'b001);
  // Colour codes double as the fase encoding: 0 rojo, 1 verde, 2 amarillo.
  assign w_col      = rojo ? 2'd0 : (verde ? 2'd1 : 2'd2);
  assign w_succ_col = (w_cur_col == 2'd2) ? 2'd0 : w_cur_col + 2'd1;

  always_comb begin
    w_cur_col = 2'd3;
    w_limit   = 4'd0;
    case (r_state)
      S_ROJO:     begin w_cur_col = 2'd0; w_limit = L_ROJO;     end
      S_VERDE:    begin w_cur_col = 2'd1; w_limit = L_VERDE;    end
      S_AMARILLO: begin w_cur_col = 2'd2; w_limit = L_AMARILLO; end
      default:    ;
    endcase
  end

  always_comb begin
    w_state_nx   = r_state;
    w_dur_nx     = r_dur;
    w_primera_nx = r_primera;
    w_fase_nx    = fase;
    w_sync_nx    = sync;
    w_err_nx     = err;
    w_code_nx    = err_code;
    w_ciclos_nx  = ciclos;
    w_viol       = 1'b0;
    w_vcode      = 3'd0;
    if (tick) begin
      case (r_state)
        S_INIT: begin
          if (w_one_hot && w_col == 2'd0) begin
            w_state_nx   = S_ROJO;
            w_dur_nx     = 4'd1;
            w_primera_nx = 1'b1;
            w_fase_nx    = 2'd0;
            w_sync_nx    = 1'b1;
          end
        end
        S_ROJO, S_VERDE, S_AMARILLO: begin
          if (!w_one_hot) begin
            w_viol  = 1'b1;
            w_vcode = 3'd1;
          end else if (w_col == w_cur_col) begin
            if (r_dur == w_limit) begin
              w_viol  = 1'b1;
              w_vcode = 3'd2;
            end else begin
              w_dur_nx = r_dur + 4'd1;
            end
          end else if (w_col == w_succ_col) begin
            // The first rojo after lock may be partial, so its length is not enforced.
            if (r_dur != w_limit && !(r_state == S_ROJO && r_primera)) begin
              w_viol  = 1'b1;
              w_vcode = 3'd3;
            end else begin
              w_state_nx   = col2state(w_col);
              w_dur_nx     = 4'd1;
              w_primera_nx = 1'b0;
              w_fase_nx    = w_col;
              if (r_state == S_AMARILLO && ciclos != '1)
                w_ciclos_nx = ciclos + CW'(1);
            end
          end else begin
            w_viol  = 1'b1;
            w_vcode = 3'd4;
          end
        end
        default: ;
      endcase
    end
    if (w_viol) begin
      w_state_nx = S_ERR;
      w_err_nx   = 1'b1;
      w_sync_nx  = 1'b0;
      w_fase_nx  = 2'd3;
      w_code_nx  = w_vcode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_dur     <= 4'd0;
      r_primera <= 1'b0;
      fase      <= 2'd3;
      sync      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 3'd0;
      ciclos    <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_dur     <= w_dur_nx;
      r_primera <= w_primera_nx;
      fase      <= w_fase_nx;
      sync      <= w_sync_nx;
      err       <= w_err_nx;
      err_code  <= w_code_nx;
      ciclos    <= w_ciclos_nx;
    end
  end

endmodule
